tm1638_frame_sched: RTL
=======================

Name: tm1638_frame_sched

Overview:
- Frame scheduler for the TM1638 display path of the digital clock.
- Snapshots the six BCD clock digits, encodes them to 7-segment codes and sequences the full TM1638 command frame (data-mode command, address command plus 16 data bytes, display-control command).
- Drives a byte-level serializer (dio/sclk shifter) over a valid/ready handshake and owns the stb line.
- Sits between the clock counters and the serializer.

Parameters:
- GAP_CYCLES, 50: minimum stb-high cycles between command groups (1 us at 50 MHz).
- REFRESH_CYCLES, 5_000_000: period of the automatic frame trigger in clk_50M cycles; 0 disables auto refresh.
- BRIGHT, 7: brightness level used when TM1638_BRIGHT_CFG_EN is off.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- frame_req  in  1  one-cycle request for an immediate frame.
- hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv  in  4 each  BCD digits.
- colon  in  1  decimal point on hour_dv and min_dv when 1.
- tx_data  out  8  byte to the serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer idle and able to accept a byte.
- stb  out  1  TM1638 strobe, active low.
- frame_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.
- brightness  in  3  present only with TM1638_BRIGHT_CFG_EN.
- disp_on  in  1  present only with TM1638_BRIGHT_CFG_EN.

Behaviour:
- Reset (async, reset=0), all outputs in the same cycle:
  - stb=1, tx_valid=0, tx_data=0x00, frame_busy=0, frame_done=0.
  - FSM=IDLE; pending flag and refresh counter cleared.
  - Reset asserted mid-frame aborts the frame immediately; no partial resume.
- Trigger sources: frame_req=1, or the refresh counter reaching REFRESH_CYCLES-1 (counter then wraps to 0).
  - A trigger in IDLE starts a frame on the next cycle.
  - A trigger while busy sets a single pending flag; further triggers are merged into it.
  - The pending frame starts the cycle after DONE.
- Frame start:
  - Latches all digits and colon into a snapshot; input changes mid-frame do not affect the frame.
  - Sets frame_busy=1.
- FSM states: IDLE -> CMD -> GAP1 -> ADDR -> DATA -> GAP2 -> CTRL -> DONE -> IDLE.
  - CMD: stb=0, send 0x40 (write, auto-increment).
  - ADDR: stb=0, send 0xC0, then 16 DATA bytes with stb held low.
  - CTRL: stb=0, send 0x80 | (disp_on<<3) | brightness.
- Byte handshake:
  - tx_valid held with tx_data stable until the cycle where tx_valid & tx_ready; tx_valid drops the next cycle unless another byte follows.
  - Back-to-back bytes within a group are allowed.
- Group end:
  - After the last byte of a group is accepted, wait until tx_ready=1 again (shifting finished), then raise stb.
  - stb stays high at least GAP_CYCLES cycles in GAP1/GAP2 before the next group lowers it.
  - stb falls at least 1 cycle before the first tx_valid of a group.
- DATA byte n, n = 0..15:
  - Even n = 2k, k = 0..5: segment code of digit k. Order: hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv.
  - Even n = 12, 14: 0x00.
  - Odd n (LED bytes): 0x00.
  - Segment codes for 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. BCD values 10-15 encode as 0x00 (blank).
  - If colon=1, bit7 is OR-ed into the codes of hour_dv and min_dv.
- DONE: frame_done=1 for one cycle, frame_busy=0, stb=1.

Optional Feature:
- Macro TM1638_BRIGHT_CFG_EN.
- Defined: brightness and disp_on ports exist; the CTRL byte is 0x80|(disp_on<<3)|brightness, sampled at frame start.
- Undefined: these ports are absent; the CTRL byte is the constant 0x88|BRIGHT (0x8F at default).

Test Plan:
- Release reset, pulse frame_req, digits 1,2,3,4,5,6, colon=0, tx_ready always 1 -> byte sequence 40 | C0 3F? no: C0 06 00 5B 00 4F 00 66 00 6D 00 7D 00 00 00 00 00 | 8F; stb low exactly around each of the 3 groups; gaps >= 50 cycles; one frame_done pulse.
- colon=1, digits 0,9,5,9,5,9 -> DATA bytes 0/2/4/6 = 3F EF 6D EF; digit 7 (hour_dv = 0xA) -> 0x00 blank.
- Serializer holds tx_ready low 20 cycles after each accept -> tx_valid/tx_data stable while waiting; stb rises only after tx_ready returns high following the last group byte.
- frame_req pulsed twice during a frame -> exactly one extra frame starts the cycle after DONE; digit changes mid-frame -> not visible in the current frame.
- REFRESH_CYCLES=1000, no frame_req -> frames start every 1000 cycles, or immediately after DONE when a trigger landed during a frame.
- Assert reset during DATA byte 5 -> stb=1 and tx_valid=0 immediately; after release and frame_req, a complete fresh frame starting with 0x40; with the macro, brightness=3 and disp_on=1 -> CTRL byte 0x8B.

Source files
------------

// File: rtl/tm1638_frame_sched.sv
// tm1638_frame_sched: snapshots six BCD digits and sequences one TM1638 frame (0x40 | 0xC0 + 16 data | ctrl).
// Latency: a frame starts the cycle after its trigger; stb falls one cycle before the first byte of each group.
// Backpressure: each byte is held on tx_valid/tx_data until tx_ready; stb rises only once tx_ready returns high.
// Option: define TM1638_BRIGHT_CFG_EN to add brightness/disp_on ports that build the display-control byte.
module tm1638_frame_sched #(
    parameter int GAP_CYCLES     = 50,
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int BRIGHT         = 7
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       frame_req,
    input  logic [3:0] hour_chuc,
    input  logic [3:0] hour_dv,
    input  logic [3:0] min_chuc,
    input  logic [3:0] min_dv,
    input  logic [3:0] sec_chuc,
    input  logic [3:0] sec_dv,
    input  logic       colon,
`ifdef TM1638_BRIGHT_CFG_EN
    input  logic [2:0] brightness,
    input  logic       disp_on,
`endif
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       stb,
    output logic       frame_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, CMD, GAP1, ADDR, DATA, GAP2, CTRL, DONE} state_t;
    // Per-group phases: stb low with no byte yet, byte(s) on the bus, waiting for the shifter to drain
    typedef enum logic [1:0] {PH_LEAD, PH_SEND, PH_DRAIN} phase_t;

    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
    localparam logic [7:0]  CTRL_CONST   = 8'h88 | {5'd0, BRIGHT[2:0]};

    state_t            state_q;
    phase_t            ph_q;
    logic              stb_q, tx_valid_q, busy_q, done_q, pend_q;
    logic [7:0]        tx_data_q, ctrl_q;
    logic [3:0]        idx_q;
    logic [15:0]       gap_q;
    logic [31:0]       refresh_q;
    logic [5:0][3:0]   snap_q;
    logic              colon_q;

    logic              refresh_hit_d, trig_d;
    logic [31:0]       refresh_d;
    logic [3:0]        byte_sel_d;
    logic [7:0]        data_byte_d, lead_byte_d, ctrl_d;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

`ifdef TM1638_BRIGHT_CFG_EN
    assign ctrl_d = {4'h8, disp_on, brightness};
`else
    assign ctrl_d = CTRL_CONST;
`endif

    // Trigger sources, the next data byte of the frame and the first byte of each group
    always_comb begin
        refresh_hit_d = 1'b0;
        if (REFRESH_CYCLES != 0 && refresh_q == REFRESH_LAST) begin
            refresh_hit_d = 1'b1;
        end
        refresh_d = (REFRESH_CYCLES == 0 || refresh_hit_d) ? 32'd0 : refresh_q + 32'd1;
        trig_d    = frame_req | refresh_hit_d;

        // ADDR hands over to data byte 0; DATA advances to the following byte
        byte_sel_d  = (state_q == ADDR) ? 4'd0 : idx_q + 4'd1;
        data_byte_d = 8'h00;
        if (!byte_sel_d[0] && byte_sel_d < 4'd12) begin
            data_byte_d = seg7(snap_q[byte_sel_d[3:1]]);
            if (colon_q && (byte_sel_d == 4'd2 || byte_sel_d == 4'd6)) begin
                data_byte_d[7] = 1'b1;
            end
        end

        case (state_q)
            CMD:     lead_byte_d = 8'h40;
            ADDR:    lead_byte_d = 8'hC0;
            default: lead_byte_d = ctrl_q;
        endcase
    end

    // Free-running auto-refresh counter
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end

    // Frame sequencer with registered stb/tx/status outputs
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ph_q       <= PH_LEAD;
            stb_q      <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            snap_q     <= '0;
            colon_q    <= 1'b0;
            ctrl_q     <= 8'h00;
        end else begin
            done_q <= 1'b0;
            // Triggers during a frame collapse into one pending request
            if (busy_q && trig_d) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (trig_d || pend_q) begin
                        snap_q  <= {sec_dv, sec_chuc, min_dv, min_chuc, hour_dv, hour_chuc};
                        colon_q <= colon;
                        ctrl_q  <= ctrl_d;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        stb_q   <= 1'b0;
                        ph_q    <= PH_LEAD;
                        state_q <= CMD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CMD, ADDR, DATA, CTRL: begin
                    case (ph_q)
                        PH_LEAD: begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= lead_byte_d;
                            ph_q       <= PH_SEND;
                        end
                        PH_SEND: begin
                            if (tx_ready) begin
                                if (state_q == ADDR) begin
                                    state_q   <= DATA;
                                    idx_q     <= 4'd0;
                                    tx_data_q <= data_byte_d;
                                end else if (state_q == DATA && idx_q != 4'd15) begin
                                    idx_q     <= idx_q + 4'd1;
                                    tx_data_q <= data_byte_d;
                                end else begin
                                    tx_valid_q <= 1'b0;
                                    ph_q       <= PH_DRAIN;
                                end
                            end
                        end
                        default: begin
                            // Shifter idle again: close the group
                            if (tx_ready) begin
                                stb_q <= 1'b1;
                                gap_q <= '0;
                                ph_q  <= PH_LEAD;
                                case (state_q)
                                    CMD:     state_q <= GAP1;
                                    DATA:    state_q <= GAP2;
                                    default: begin
                                        state_q <= DONE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
                GAP1, GAP2: begin
                    if (gap_q == GAP_LAST) begin
                        stb_q   <= 1'b0;
                        ph_q    <= PH_LEAD;
                        state_q <= (state_q == GAP1) ? ADDR : CTRL;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign stb        = stb_q;
    assign frame_busy = busy_q;
    assign frame_done = done_q;

endmodule
